// File: rtl/biriscv_mul_writeback.sv
// Shadow pipeline that pairs multiplier results with their rd/pc metadata and
// publishes writeback, pending-destination mask and a retired-multiply counter.
module biriscv_mul_writeback #(
  parameter int unsigned MULT_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        opcode_valid_i,
  input  logic        opcode_is_mul_i,
  input  logic        opcode_invalid_i,
  input  logic [4:0]  opcode_rd_idx_i,
  input  logic [31:0] opcode_pc_i,
  input  logic        hold_i,
  input  logic        flush_i,
  input  logic [31:0] mul_value_i,
  output logic        writeback_valid_o,
  output logic [4:0]  writeback_rd_idx_o,
  output logic [31:0] writeback_pc_o,
  output logic [31:0] writeback_value_o,
  output logic [31:0] pending_rd_mask_o,
  output logic [31:0] mul_retired_count_o
);

  localparam int unsigned Last = MULT_STAGES - 1;

  logic [MULT_STAGES-1:0]       valid_q;
  logic [MULT_STAGES-1:0][4:0]  rd_q;
  logic [MULT_STAGES-1:0][31:0] pc_q;
  logic [31:0]                  count_q;
  logic                         accept;
  logic                         retire;

  assign accept = opcode_valid_i & opcode_is_mul_i & ~opcode_invalid_i & ~hold_i & ~flush_i;
  assign retire = valid_q[Last] & ~hold_i & ~flush_i;

  // Flush wins over hold; rd/pc may go stale since every consumer is valid-qualified.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (!hold_i) begin
      valid_q <= {valid_q[MULT_STAGES-2:0], accept};
      rd_q    <= {rd_q[MULT_STAGES-2:0], opcode_rd_idx_i};
      pc_q    <= {pc_q[MULT_STAGES-2:0], opcode_pc_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    pending_rd_mask_o = '0;
    for (int unsigned i = 0; i < MULT_STAGES; i++) begin
      if (valid_q[i]) begin
        pending_rd_mask_o[rd_q[i]] = 1'b1;
      end
    end
    // x0 never creates a hazard.
    pending_rd_mask_o[0] = 1'b0;
  end

  assign writeback_valid_o   = valid_q[Last];
  assign writeback_rd_idx_o  = valid_q[Last] ? rd_q[Last] : 5'd0;
  assign writeback_pc_o      = valid_q[Last] ? pc_q[Last] : 32'd0;
  assign writeback_value_o   = mul_value_i;
  assign mul_retired_count_o = count_q;

endmodule
